// File: rtl/wdf_pkg.sv
// Shared types and constants for the WDF pattern checker.
// Holds the run-state enum, the mismatch-counter default width and the mask polarity.
package wdf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wdf_state_e;

    localparam int unsigned WDF_CNT_W = 16;

    // A mask bit at this level marks the signal as don't-care.
    localparam logic WDF_MASK_DONT_CARE = 1'b1;

endpackage

// File: rtl/wdf_expected_ram.sv
// Expected-pattern memory: one write port, one synchronous read port, no reset.
// Ports: clk_i; we_i/waddr_i/wdata_i write; re_i/raddr_i read; rdata_o registered read data.
module wdf_expected_ram
    import wdf_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             rd_en;

    // A collision on the same address suppresses the read; the write wins.
    assign rd_en = re_i && !(we_i && (waddr_i == raddr_i));

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (rd_en) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/wdf_pattern_checker.sv
// Receive-side WDF checker: compares sampled vectors against a preloaded expected pattern.
// Ports: clk/reset; cfg_* memory load; start arms a run; sample_* stream in; status/result outputs.
module wdf_pattern_checker
    import wdf_pkg::*;
#(
    parameter int unsigned NUM_SIGNALS                       = 8,
    parameter int unsigned TOTAL_NUMBER_OF_SAMPLES           = 1024,
    parameter int unsigned ADDR_W                            = $clog2(TOTAL_NUMBER_OF_SAMPLES),
    parameter int unsigned CURRENT_SAMPLE_COUNTER_START_FROM = 0,
    parameter int unsigned CNT_W                             = WDF_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_we,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic [NUM_SIGNALS-1:0] cfg_data,
    input  logic [NUM_SIGNALS-1:0] cfg_mask,
    input  logic                   start,
    input  logic                   sample_valid,
    input  logic [NUM_SIGNALS-1:0] sample_data,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_W-1:0]       mismatch_count,
    output logic                   first_mismatch_valid,
    output logic [31:0]            first_mismatch_index,
    output logic                   extra_samples
);

    // One extra bit so the index can reach TOTAL and stop acceptance.
    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned MEM_W = 2 * NUM_SIGNALS;

    localparam logic [IDX_W-1:0]  TOTAL_IDX = IDX_W'(TOTAL_NUMBER_OF_SAMPLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_NUMBER_OF_SAMPLES - 1);

    wdf_state_e state_q;
    logic       busy_q;
    logic       done_q;

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    // Stage 1: sample and its index, aligned with the RAM read data.
    logic                   s1_valid_q;
    logic [NUM_SIGNALS-1:0] s1_data_q;
    logic [ADDR_W-1:0]      s1_idx_q;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             fm_valid_q;
    logic             fm_valid_d;
    logic [31:0]      fm_index_q;
    logic [31:0]      fm_index_d;
    logic             extra_q;
    logic             extra_d;

    logic [MEM_W-1:0]       rd_data;
    logic [NUM_SIGNALS-1:0] exp_data;
    logic [NUM_SIGNALS-1:0] exp_mask;
    logic [NUM_SIGNALS-1:0] care;

    logic accept;
    logic arm;
    logic cfg_wr;
    logic mismatch;
    logic last_cmp;

    wdf_expected_ram #(
        .WIDTH (MEM_W),
        .DEPTH (TOTAL_NUMBER_OF_SAMPLES),
        .AW    (ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (cfg_wr),
        .waddr_i (cfg_addr),
        .wdata_i ({cfg_mask, cfg_data}),
        .re_i    (accept),
        .raddr_i (idx_q[ADDR_W-1:0]),
        .rdata_o (rd_data)
    );

    always_comb begin
        accept   = (state_q == RUN) && sample_valid && (idx_q < TOTAL_IDX);
        arm      = start && (state_q != RUN);
        cfg_wr   = cfg_we && (state_q != RUN);

        exp_mask = rd_data[MEM_W-1:NUM_SIGNALS];
        exp_data = rd_data[NUM_SIGNALS-1:0];
        care     = WDF_MASK_DONT_CARE ? ~exp_mask : exp_mask;

        mismatch = s1_valid_q && (|((s1_data_q ^ exp_data) & care));
        last_cmp = s1_valid_q && (s1_idx_q == LAST_ADDR);
    end

    always_comb begin
        idx_d = idx_q;
        if (arm) begin
            idx_d = '0;
        end else if (accept) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        fm_valid_d = fm_valid_q;
        fm_index_d = fm_index_q;
        extra_d    = extra_q;
        if (arm) begin
            cnt_d      = '0;
            fm_valid_d = 1'b0;
            fm_index_d = '0;
            extra_d    = 1'b0;
        end else begin
            if (mismatch) begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!fm_valid_q) begin
                    fm_valid_d = 1'b1;
                    fm_index_d = CURRENT_SAMPLE_COUNTER_START_FROM
                               + 32'(s1_idx_q);
                end
            end
            if ((state_q == DONE) && sample_valid) begin
                extra_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_cmp) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_idx_q   <= '0;
            cnt_q      <= '0;
            fm_valid_q <= 1'b0;
            fm_index_q <= '0;
            extra_q    <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            s1_valid_q <= accept;
            if (accept) begin
                s1_data_q <= sample_data;
                s1_idx_q  <= idx_q[ADDR_W-1:0];
            end
            cnt_q      <= cnt_d;
            fm_valid_q <= fm_valid_d;
            fm_index_q <= fm_index_d;
            extra_q    <= extra_d;
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign pass                 = done_q && (cnt_q == '0) && !extra_q;
    assign mismatch_count       = cnt_q;
    assign first_mismatch_valid = fm_valid_q;
    assign first_mismatch_index = fm_index_q;
    assign extra_samples        = extra_q;

endmodule
